instr_decoder: RTL and testbench

//  Registered instruction decoder for the 8-bit ELVM-style CPU core.

---
 rtl/instr_decoder_if.sv | 32 +++
 rtl/instr_decoder.sv | 65 ++++++
 tb/tb_instr_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/instr_decoder_if.sv
// Bus between program ROM / fetch side and the instruction decoder.
// The fetch side (master) supplies the word and the enable; the decoder
// (slave) returns the registered fields and class flags.
interface instr_decoder_if #(
    parameter int IW = 26
);
    logic          en;
    logic [IW-1:0] instr;
    logic [4:0]    op;
    logic          is_src_im;
    logic          is_neg;
    logic [7:0]    rd_p;
    logic [2:0]    rs_p;
    logic [7:0]    im;
    logic          is_alu;
    logic          is_mem;
    logic          is_branch;
    logic          pc_inc;
    logic          illegal;

    modport master (
        output en, instr,
        input  op, is_src_im, is_neg, rd_p, rs_p, im,
               is_alu, is_mem, is_branch, pc_inc, illegal
    );

    modport slave (
        input  en, instr,
        output op, is_src_im, is_neg, rd_p, rs_p, im,
               is_alu, is_mem, is_branch, pc_inc, illegal
    );
endinterface

// File: rtl/instr_decoder.sv
// Registered instruction decoder for the 8-bit ELVM-style CPU core.
// Splits a 26-bit ROM word into opcode/operand/immediate fields and derives
// class flags used by the execute stage for PC sequencing. One cycle latency.
// Optional feature: define NEG_IM_EN to have the decoder negate the
// immediate when the sign bit is set; otherwise the raw immediate passes
// through and sign handling is left to the execute stage.
module instr_decoder #(
    parameter int IW = 26
) (
    input  logic             clk,
    input  logic             rst,
    instr_decoder_if.slave   bus
);
    localparam int OP_LSB = IW - 5;

    logic [4:0] op_next;
    logic [7:0] im_next;
    logic       is_alu_next;
    logic       is_mem_next;
    logic       is_branch_next;
    logic       illegal_next;

    // Decode the opcode class flags and immediate from the incoming word.
    always_comb begin
        op_next        = bus.instr[IW-1:OP_LSB];
        is_alu_next    = (op_next <= 5'd2) || ((op_next >= 5'd8) && (op_next <= 5'd13));
        is_mem_next    = (op_next == 5'd3) || (op_next == 5'd4);
        is_branch_next = (op_next >= 5'd14) && (op_next <= 5'd20);
        illegal_next   = (op_next == 5'd7) || ((op_next >= 5'd23) && (op_next <= 5'd30));
`ifdef NEG_IM_EN
        im_next = bus.instr[19] ? (8'd0 - bus.instr[7:0]) : bus.instr[7:0];
`else
        im_next = bus.instr[7:0];
`endif
    end

    // Register fields and flags together; reset parks the stage on a nop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.op        <= 5'h1F;
            bus.is_src_im <= 1'b0;
            bus.is_neg    <= 1'b0;
            bus.rd_p      <= 8'd0;
            bus.rs_p      <= 3'd0;
            bus.im        <= 8'd0;
            bus.is_alu    <= 1'b0;
            bus.is_mem    <= 1'b0;
            bus.is_branch <= 1'b0;
            bus.pc_inc    <= 1'b1;
            bus.illegal   <= 1'b0;
        end else if (bus.en) begin
            bus.op        <= op_next;
            bus.is_src_im <= bus.instr[20];
            bus.is_neg    <= bus.instr[19];
            bus.rd_p      <= bus.instr[18:11];
            bus.rs_p      <= bus.instr[10:8];
            bus.im        <= im_next;
            bus.is_alu    <= is_alu_next;
            bus.is_mem    <= is_mem_next;
            bus.is_branch <= is_branch_next;
            bus.pc_inc    <= !is_branch_next;
            bus.illegal   <= illegal_next;
        end
    end
endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: a reference model computes the
// expected decoded word per stimulus, pushes it to a scoreboard queue, and
// the queue is popped and compared one cycle later.
module tb_instr_decoder;
    logic clk;
    logic rst;
    logic clk_run;

    int compared;
    int mismatched;

    logic [30:0] exp_q[$];
    logic [30:0] last_exp;

    instr_decoder_if #(.IW(26)) bus ();

    instr_decoder #(.IW(26)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gated free-running clock so the reset can be checked with no edges.
    initial clk = 1'b0;
    always #5 clk = clk_run ? ~clk : 1'b0;

    // Pack a set of fields into one comparable vector.
    function automatic logic [30:0] pack(logic [4:0] op, logic src, logic neg,
                                         logic [7:0] rd, logic [2:0] rs, logic [7:0] im,
                                         logic alu, logic mem, logic br, logic pci, logic ill);
        return {op, src, neg, rd, rs, im, alu, mem, br, pci, ill};
    endfunction

    // Reference model built from the opcode table.
    function automatic logic [30:0] model(logic [25:0] w);
        logic [4:0] op;
        logic [7:0] im;
        logic alu, mem, br, ill;
        op  = w[25:21];
        alu = 1'b0; mem = 1'b0; br = 1'b0; ill = 1'b0;
        case (op) inside
            5'd0, 5'd1, 5'd2, [5'd8:5'd13]: alu = 1'b1;
            5'd3, 5'd4:                     mem = 1'b1;
            [5'd14:5'd20]:                  br  = 1'b1;
            5'd7, [5'd23:5'd30]:            ill = 1'b1;
            default: ;
        endcase
        im = w[7:0];
`ifdef NEG_IM_EN
        if (w[19]) im = ~w[7:0] + 8'd1;
`endif
        return pack(op, w[20], w[19], w[18:11], w[10:8], im, alu, mem, br, !br, ill);
    endfunction

    function automatic logic [30:0] observed();
        return pack(bus.op, bus.is_src_im, bus.is_neg, bus.rd_p, bus.rs_p, bus.im,
                    bus.is_alu, bus.is_mem, bus.is_branch, bus.pc_inc, bus.illegal);
    endfunction

    localparam logic [30:0] RESET_EXP = {5'h1F, 1'b0, 1'b0, 8'd0, 3'd0, 8'd0, 4'b0001, 1'b0};

    task automatic checkOutput(input string tag, input logic [30:0] obs, input logic [30:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Pop the next expectation and compare it against the live outputs.
    task automatic scoreCheck(input string tag);
        logic [30:0] exp;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: scoreboard empty got %08h expected entry", tag, observed());
        end else begin
            exp = exp_q.pop_front();
            checkOutput(tag, observed(), exp);
        end
    endtask

    // Drive one word between edges, predict, then check after the edge.
    task automatic applyStimulus(input string tag, input logic [25:0] w, input logic e);
        @(negedge clk);
        bus.instr = w;
        bus.en    = e;
        if (e) last_exp = model(w);
        exp_q.push_back(last_exp);
        @(posedge clk);
        #1;
        scoreCheck(tag);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clk_run    = 1'b0;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.instr  = 26'd0;
        last_exp   = RESET_EXP;
        #3;
        exp_q.push_back(RESET_EXP);
        scoreCheck("reset_state");
        rst = 1'b0;
        clk_run = 1'b1;

        applyStimulus("mov_imm", 26'h0100041, 1'b1);
        checkOutput("mov_im_field", {24'd0, bus.im}, 32'h41);
        applyStimulus("jeq", 26'h1C01105, 1'b1);
        checkOutput("jeq_pc_inc", {31'd0, bus.pc_inc}, 32'd0);
        applyStimulus("op25", 26'h3200000, 1'b1);
        checkOutput("op25_illegal", {31'd0, bus.illegal}, 32'd1);
        applyStimulus("op7", 26'h0E00000, 1'b1);
        applyStimulus("op31_nop", 26'h3E00000, 1'b1);
        checkOutput("op31_illegal", {31'd0, bus.illegal}, 32'd0);
        applyStimulus("sub_neg", 26'h0580003, 1'b1);
`ifdef NEG_IM_EN
        checkOutput("sub_neg_im", {24'd0, bus.im}, 32'hFD);
`else
        checkOutput("sub_neg_im", {24'd0, bus.im}, 32'h03);
`endif
        applyStimulus("neg_zero", 26'h0080000, 1'b1);
        applyStimulus("neg_0x80", 26'h0080080, 1'b1);

        // Hold: en low for three edges with changing words.
        applyStimulus("hold_load", 26'h0600A01, 1'b1);
        applyStimulus("hold_1", 26'h1E12345, 1'b0);
        applyStimulus("hold_2", 26'h2A0FFFF, 1'b0);
        applyStimulus("hold_3", 26'h3FFFFFF, 1'b0);
        applyStimulus("hold_release", 26'h2812345, 1'b1);

        // Every opcode with a fixed operand pattern.
        for (int o = 0; o < 32; o++) begin
            applyStimulus($sformatf("opcode_%0d", o), {o[4:0], 21'h1A5A5A}, 1'b1);
        end

        // Asynchronous reset with the clock stopped.
        @(negedge clk);
        clk_run = 1'b0;
        #20;
        rst = 1'b1;
        #1;
        exp_q.push_back(RESET_EXP);
        scoreCheck("async_reset");
        last_exp = RESET_EXP;

        // Reset held across an edge with en high: reset wins.
        bus.instr = 26'h0100041;
        bus.en    = 1'b1;
        clk_run   = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(RESET_EXP);
        scoreCheck("rst_over_en");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("after_reset", 26'h1C01105, 1'b1);

        // Random mix of words and enables.
        for (int i = 0; i < 60; i++) begin
            applyStimulus("random", 26'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        clk_run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
